// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small write FIFO, paced by a shared 16x baud Tick enable.
// TXD, TXD_BUSY and TXD_OVER are all registered so the line is glitch-free.
module uart_transmitter #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Tick,
  input  logic [DATA_BITS-1:0] TXD_DATA,
  input  logic                 TXD_WR,
  output logic                 TXD_FULL,
  output logic                 TXD_BUSY,
  output logic                 TXD_OVER,
  output logic                 TXD
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                   full_q, full_d, empty_q, empty_d;
  logic                   busy_q, busy_d, over_q, over_d, txd_q, txd_d;
  logic                   pop, wr_en, last_tick;
  logic [DATA_BITS-1:0]   head;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign last_tick = Tick && (cnt_q == CW'(OVERSAMPLE - 1));
  // A write into a full FIFO still lands when the head is popped in the same cycle.
  assign wr_en     = TXD_WR && (!full_q || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= TXD_DATA;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    over_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Tick && !empty_q) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (Tick) cnt_d = cnt_q + CW'(1);
        if (last_tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (Tick) cnt_d = cnt_q + CW'(1);
        if (last_tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == BW'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (Tick) cnt_d = cnt_q + CW'(1);
        if (last_tick) begin
          over_d = 1'b1;
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = head;
            cnt_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    busy_d   = (state_d != IDLE) || !empty_d;

    txd_d = 1'b1;
    if (state_d == START)     txd_d = 1'b0;
    else if (state_d == DATA) txd_d = shift_d[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
      txd_q    <= txd_d;
    end
  end

  assign TXD_FULL = full_q;
  assign TXD_BUSY = busy_q;
  assign TXD_OVER = over_q;
  assign TXD      = txd_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: written bytes are queued, and a line
// monitor decodes each frame by counting Ticks and compares against the queue.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       Tick;
  logic [7:0] TXD_DATA;
  logic       TXD_WR;
  logic       TXD_FULL, TXD_BUSY, TXD_OVER, TXD;

  uart_transmitter #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .Tick(Tick), .TXD_DATA(TXD_DATA), .TXD_WR(TXD_WR),
    .TXD_FULL(TXD_FULL), .TXD_BUSY(TXD_BUSY), .TXD_OVER(TXD_OVER), .TXD(TXD)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  int   k = 0;
  logic in_frame = 1'b0;
  int   frames_done = 0;
  int   b2b_cnt = 0;
  int   over_cnt = 0;
  logic tick_en = 1'b0;
  event tick_rise;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tick generator: one pulse every 4 clk while enabled, driven on the falling edge.
  initial begin
    int phase = 0;
    Tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        phase = (phase + 1) % 4;
        Tick  = (phase == 0);
        if (Tick) ->tick_rise;
      end else begin
        Tick = 1'b0;
      end
    end
  end

  // Line monitor: samples outputs 1 time unit after each rising edge.
  initial begin
    logic ts;
    logic over_now;
    logic bits [10];
    logic [7:0] got_byte;
    logic [7:0] exp_byte;
    forever begin
      @(posedge clk);
      ts = Tick;
      #1;
      over_now = 1'b0;
      if (!rst) begin
        in_frame = 1'b0;
        k = 0;
      end else begin
        if (in_frame && ts) begin
          k++;
          if (k % 16 == 8) bits[k / 16] = TXD;
          if (k == 160) begin
            over_now = 1'b1;
            frames_done++;
            for (int i = 0; i < 8; i++) got_byte[i] = bits[i + 1];
            check("start_bit", {31'd0, bits[0]}, 32'd0);
            check("stop_bit", {31'd0, bits[9]}, 32'd1);
            if (exp_q.size() == 0) begin
              check("frame_unexpected", 32'd1, 32'd0);
            end else begin
              exp_byte = exp_q.pop_front();
              check("frame_data", {24'd0, got_byte}, {24'd0, exp_byte});
              $display("frame %0d: got %02h expected %02h", frames_done, got_byte, exp_byte);
            end
            if (TXD == 1'b0) begin
              b2b_cnt++;
              k = 0;
            end else begin
              in_frame = 1'b0;
            end
          end
        end else if (!in_frame && TXD == 1'b0) begin
          in_frame = 1'b1;
          k = 0;
        end
        if (TXD_OVER) over_cnt++;
        if (TXD_OVER || over_now) check("over_pulse", {31'd0, TXD_OVER}, {31'd0, over_now});
      end
    end
  end

  task automatic write_byte(input logic [7:0] b, input logic accept);
    @(negedge clk);
    TXD_WR = 1'b1;
    TXD_DATA = b;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    TXD_WR = 1'b0;
    $display("write %02h accept_expected=%0d", b, accept);
  endtask

  task automatic write_burst(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] v [3];
    v[0] = b0; v[1] = b1; v[2] = b2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      TXD_WR = 1'b1;
      TXD_DATA = v[i];
      exp_q.push_back(v[i]);
      $display("write %02h accept_expected=1", v[i]);
    end
    @(negedge clk);
    TXD_WR = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_frame && !TXD_BUSY) done = 1'b1;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_frame(input string tag);
    logic done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (in_frame) done = 1'b1;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int o0, f0, b0;
    logic seen, stayed_low;
    rst = 1'b0;
    TXD_WR = 1'b0;
    TXD_DATA = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_txd", {31'd0, TXD}, 32'd1);
    check("reset_full", {31'd0, TXD_FULL}, 32'd0);
    check("reset_busy", {31'd0, TXD_BUSY}, 32'd0);
    check("reset_over", {31'd0, TXD_OVER}, 32'd0);
    rst = 1'b1;
    tick_en = 1'b1;

    // Single byte
    o0 = over_cnt;
    write_byte(8'h55, 1'b1);
    check("busy_after_write", {31'd0, TXD_BUSY}, 32'd1);
    wait_idle("single_drain");
    check("single_over_cnt", over_cnt - o0, 32'd1);
    check("single_busy_low", {31'd0, TXD_BUSY}, 32'd0);

    // Back-to-back
    o0 = over_cnt;
    b0 = b2b_cnt;
    write_burst(8'hA3, 8'h00, 8'hFF);
    wait_idle("b2b_drain");
    check("b2b_over_cnt", over_cnt - o0, 32'd3);
    check("b2b_no_gap", b2b_cnt - b0, 32'd2);

    // FIFO full with Tick held low
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 5) check("full_after_4", {31'd0, TXD_FULL}, 32'd1);
      TXD_WR = 1'b1;
      TXD_DATA = 8'(i);
      if (i <= 4) exp_q.push_back(8'(i));
      $display("write %02h accept_expected=%0d", i, i <= 4);
    end
    @(negedge clk);
    TXD_WR = 1'b0;
    check("full_hold", {31'd0, TXD_FULL}, 32'd1);
    tick_en = 1'b1;
    wait_frame("full_first_frame");
    check("full_clear_on_pop", {31'd0, TXD_FULL}, 32'd0);
    wait_idle("full_drain");

    // Write coinciding with a STOP-end pop while full
    write_byte(8'h11, 1'b1);
    wait_frame("wdp_first_frame");
    write_burst(8'h21, 8'h22, 8'h23);
    write_byte(8'h24, 1'b1);
    check("wdp_full", {31'd0, TXD_FULL}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(tick_rise);
      if (in_frame && k == 159) begin
        seen = 1'b1;
        TXD_WR = 1'b1;
        TXD_DATA = 8'h25;
        exp_q.push_back(8'h25);
        $display("write 25 accept_expected=1 (coincides with pop)");
      end
    end
    check("wdp_align", {31'd0, seen}, 32'd1);
    @(negedge clk);
    TXD_WR = 1'b0;
    check("wdp_still_full", {31'd0, TXD_FULL}, 32'd1);
    wait_idle("wdp_drain");

    // Reset during DATA bit 3
    write_burst(8'h0F, 8'h33, 8'h44);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (in_frame && k == 70) seen = 1'b1;
    end
    check("rst_reach_bit3", {31'd0, seen}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_txd", {31'd0, TXD}, 32'd1);
    check("rst_busy", {31'd0, TXD_BUSY}, 32'd0);
    check("rst_full", {31'd0, TXD_FULL}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    f0 = frames_done;
    stayed_low = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (TXD !== 1'b1 || TXD_BUSY !== 1'b0) stayed_low = 1'b1;
    end
    check("rst_line_quiet", {31'd0, stayed_low}, 32'd0);
    check("rst_no_frames", frames_done - f0, 32'd0);

    // Tick stall in the middle of the start bit
    write_byte(8'hC6, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (in_frame && k == 8) seen = 1'b1;
    end
    check("stall_reach", {31'd0, seen}, 32'd1);
    tick_en = 1'b0;
    stayed_low = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (TXD !== 1'b0) stayed_low = 1'b0;
    end
    check("stall_txd_low", {31'd0, stayed_low}, 32'd1);
    tick_en = 1'b1;
    wait_idle("stall_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
